uart_tx_ctrl: RTL and testbench



---
 rtl/uart_tx_ctrl_if.sv | 42 ++++
 rtl/uart_tx_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_if
// Handshake/control bundle between the UART TX frame sequencer and its
// neighbours (TX data source, serializer, parity calculator, output mux).
//
// Signals:
//   data_valid  source -> ctrl  new byte available on the TX data bus
//   par_en      source -> ctrl  parity enable, sampled at frame acceptance
//   par_load    ctrl -> parity  one-cycle capture strobe
//   ser_load    ctrl -> serial  one-cycle capture strobe (with par_load)
//   ser_en      ctrl -> serial  shift enable during DATA
//   bit_cnt     ctrl -> *       index of the data bit on the line, 0 otherwise
//   mux_sel     ctrl -> mux     00 start, 01 stop/idle, 10 data, 11 parity
//   busy        ctrl -> *       frame in progress
//
// Modports: master = the side driving data_valid/par_en (source / bench),
//           slave  = the frame sequencer.
// -----------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic             data_valid;
  logic             par_en;
  logic             par_load;
  logic             ser_load;
  logic             ser_en;
  logic [CNT_W-1:0] bit_cnt;
  logic [1:0]       mux_sel;
  logic             busy;

  modport master (
    output data_valid, par_en,
    input  par_load, ser_load, ser_en, bit_cnt, mux_sel, busy
  );

  modport slave (
    input  data_valid, par_en,
    output par_load, ser_load, ser_en, bit_cnt, mux_sel, busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// Frame sequencer for the UART transmit path. Accepts a byte-valid strobe,
// pulses the serializer/parity load strobes and steps the frame
// START -> DATA x DATA_WIDTH -> [PARITY] -> STOP, one UART bit per clk.
// Back-to-back frames are accepted in the final stop cycle with no idle gap.
//
// Ports:
//   clk  TX bit clock
//   rst  asynchronous active-low reset
//   bus  uart_tx_ctrl_if.slave (data_valid/par_en in; load strobes, ser_en,
//        bit_cnt, mux_sel, busy out)
//
// Every output is a flop: the value loaded on an edge is the value for the
// state being entered, so there is no input-to-output combinational path.
// The load strobes are therefore high during the first START cycle, i.e. the
// cycle right after the accepting edge.
//
// Build option: define UART_TX_TWO_STOP_EN to add a second stop bit (STOP2);
// back-to-back acceptance then moves from STOP to STOP2.
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_ctrl_if.slave bus
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_STOP   = 2'b01;
  localparam logic [1:0] MUX_DATA   = 2'b10;
  localparam logic [1:0] MUX_PARITY = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
    STOP   = 3'd4,
    STOP2  = 3'd5
`else
    STOP   = 3'd4
`endif
  } state_e;

  state_e           state_q;
  logic             par_load_q;
  logic             ser_load_q;
  logic             ser_en_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [1:0]       mux_sel_q;
  logic             busy_q;
  logic             par_en_q;

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking would chain them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      par_load_q <= 1'b0;
      ser_load_q <= 1'b0;
      ser_en_q   <= 1'b0;
      bit_cnt_q  <= '0;
      mux_sel_q  <= MUX_STOP;
      busy_q     <= 1'b0;
      par_en_q   <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle so they can only ever be
      // one-cycle pulses; only the accepting branch raises them.
      par_load_q <= 1'b0;
      ser_load_q <= 1'b0;

      case (state_q)
        // Acceptance points: IDLE, and the final stop cycle of a frame.
`ifdef UART_TX_TWO_STOP_EN
        IDLE, STOP2: begin
`else
        IDLE, STOP: begin
`endif
          if (bus.data_valid) begin
            state_q    <= START;
            par_load_q <= 1'b1;
            ser_load_q <= 1'b1;
            par_en_q   <= bus.par_en;
            mux_sel_q  <= MUX_START;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= IDLE;
            mux_sel_q  <= MUX_STOP;
            busy_q     <= 1'b0;
          end
          ser_en_q  <= 1'b0;
          bit_cnt_q <= '0;
        end

        START: begin
          state_q   <= DATA;
          mux_sel_q <= MUX_DATA;
          ser_en_q  <= 1'b1;
          bit_cnt_q <= '0;
          busy_q    <= 1'b1;
        end

        DATA: begin
          busy_q <= 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            ser_en_q  <= 1'b0;
            bit_cnt_q <= '0;
            if (par_en_q) begin
              state_q   <= PARITY;
              mux_sel_q <= MUX_PARITY;
            end else begin
              state_q   <= STOP;
              mux_sel_q <= MUX_STOP;
            end
          end else begin
            bit_cnt_q <= CNT_W'(bit_cnt_q + 1'b1);
          end
        end

        PARITY: begin
          state_q   <= STOP;
          mux_sel_q <= MUX_STOP;
          busy_q    <= 1'b1;
        end

`ifdef UART_TX_TWO_STOP_EN
        STOP: begin
          state_q   <= STOP2;
          mux_sel_q <= MUX_STOP;
          busy_q    <= 1'b1;
        end
`endif

        // Unreachable encodings fall back to idle outputs on the next edge.
        default: begin
          state_q   <= IDLE;
          mux_sel_q <= MUX_STOP;
          ser_en_q  <= 1'b0;
          bit_cnt_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.par_load = par_load_q;
  assign bus.ser_load = ser_load_q;
  assign bus.ser_en   = ser_en_q;
  assign bus.bit_cnt  = bit_cnt_q;
  assign bus.mux_sel  = mux_sel_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Self-checking bench for uart_tx_ctrl. A frame-level model expands every
// accepted byte into the list of per-cycle line states it must produce
// (start, DATA_WIDTH data bits, optional parity, stop bit(s)); a compare
// process checks the DUT against the head of that list on every falling edge.
// Directed tests also pin frame lengths and pulse counts against literals.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;
  localparam int DW = 8;
  localparam int CW = 3;
`ifdef UART_TX_TWO_STOP_EN
  localparam int FRAME_NP = 11;
  localparam int FRAME_P  = 12;
`else
  localparam int FRAME_NP = 10;
  localparam int FRAME_P  = 11;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct packed {
    logic [1:0]    mux;
    logic [CW-1:0] cnt;
    logic          ser_en;
    logic          busy;
    logic          load;
    logic          can_accept;   // a new byte may be taken at the end of this cycle
  } exp_t;

  localparam exp_t IDLE_E = '{mux: 2'b01, cnt: '0, ser_en: 1'b0, busy: 1'b0,
                              load: 1'b0, can_accept: 1'b1};

  exp_t q[$];
  exp_t cur = IDLE_E;

  function automatic exp_t mk(input logic [1:0] m, input int c, input logic se,
                              input logic ld, input logic acc);
    exp_t e;
    e.mux = m; e.cnt = CW'(c); e.ser_en = se; e.busy = 1'b1;
    e.load = ld; e.can_accept = acc;
    return e;
  endfunction

  task automatic build_frame(input logic with_parity);
    q.delete();
    q.push_back(mk(2'b00, 0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < DW; i++) q.push_back(mk(2'b10, i, 1'b1, 1'b0, 1'b0));
    if (with_parity) q.push_back(mk(2'b11, 0, 1'b0, 1'b0, 1'b0));
`ifdef UART_TX_TWO_STOP_EN
    q.push_back(mk(2'b01, 0, 1'b0, 1'b0, 1'b0));
`endif
    q.push_back(mk(2'b01, 0, 1'b0, 1'b0, 1'b1));
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      cur = IDLE_E;
    end else if (cur.can_accept && bus.data_valid === 1'b1) begin
      build_frame(bus.par_en);
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = IDLE_E;
    end
  end

  // ---------------- per-cycle compare + counters ----------------
  int busy_cycles = 0;
  int load_cnt    = 0;
  int par_cycles  = 0;
  int data_cycles = 0;

  always @(negedge clk) begin
    check("mux_sel",  {30'd0, bus.mux_sel},  {30'd0, cur.mux});
    check("bit_cnt",  {29'd0, bus.bit_cnt},  {29'd0, cur.cnt});
    check("ser_en",   {31'd0, bus.ser_en},   {31'd0, cur.ser_en});
    check("busy",     {31'd0, bus.busy},     {31'd0, cur.busy});
    check("ser_load", {31'd0, bus.ser_load}, {31'd0, cur.load});
    check("par_load", {31'd0, bus.par_load}, {31'd0, cur.load});
    if (bus.busy === 1'b1)         busy_cycles++;
    if (bus.ser_load === 1'b1)     load_cnt++;
    if (bus.mux_sel === 2'b11)     par_cycles++;
    if (bus.ser_en === 1'b1)       data_cycles++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_counts();
    @(posedge clk);
    #1;
    busy_cycles = 0; load_cnt = 0; par_cycles = 0; data_cycles = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_dv();
    @(negedge clk);
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  // Wait (bounded) until the DUT is sending data bit b; leaves us just after a negedge.
  task automatic wait_bit(input int b, output logic found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.ser_en === 1'b1 && bus.bit_cnt === CW'(b)) found = 1'b1;
    end
  endtask

  logic found;

  initial begin
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;

    // 1. reset held, then idle
    idle_cycles(3);
    check("rst_mux",  {30'd0, bus.mux_sel}, 32'h1);
    check("rst_busy", {31'd0, bus.busy},    32'h0);
    rst = 1'b1;
    clear_counts();
    idle_cycles(20);
    check("idle_busy_cycles", busy_cycles, 0);
    check("idle_loads",       load_cnt,    0);

    // 2. single frame, no parity
    clear_counts();
    bus.par_en = 1'b0;
    pulse_dv();
    idle_cycles(FRAME_NP + 3);
    check("np_busy_cycles", busy_cycles, FRAME_NP);
    check("np_loads",       load_cnt,    1);
    check("np_data_cycles", data_cycles, 8);
    check("np_par_cycles",  par_cycles,  0);

    // 3. parity frame; par_en dropped mid-frame must not matter
    clear_counts();
    bus.par_en = 1'b1;
    pulse_dv();
    idle_cycles(3);
    bus.par_en = 1'b0;
    idle_cycles(FRAME_P + 2);
    check("p_busy_cycles", busy_cycles, FRAME_P);
    check("p_par_cycles",  par_cycles,  1);
    check("p_data_cycles", data_cycles, 8);

    // 4. three back-to-back frames with data_valid held high
    clear_counts();
    bus.par_en = 1'b0;
    @(negedge clk);
    bus.data_valid = 1'b1;
    idle_cycles(3 * FRAME_NP);
    bus.data_valid = 1'b0;
    idle_cycles(4);
    check("b2b_busy_cycles", busy_cycles, 3 * FRAME_NP);
    check("b2b_loads",       load_cnt,    3);

    // 5. data_valid during DATA bit 3 is ignored
    clear_counts();
    pulse_dv();
    wait_bit(3, found);
    check("reach_bit3", {31'd0, found}, 32'h1);
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    idle_cycles(FRAME_NP);
    check("ign_busy_cycles", busy_cycles, FRAME_NP);
    check("ign_loads",       load_cnt,    1);

    // 6. async reset at bit 5, then a clean frame
    pulse_dv();
    wait_bit(5, found);
    check("reach_bit5", {31'd0, found}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("arst_mux",    {30'd0, bus.mux_sel}, 32'h1);
    check("arst_busy",   {31'd0, bus.busy},    32'h0);
    check("arst_ser_en", {31'd0, bus.ser_en},  32'h0);
    check("arst_cnt",    {29'd0, bus.bit_cnt}, 32'h0);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(3);
    clear_counts();
    pulse_dv();
    idle_cycles(FRAME_NP + 3);
    check("post_rst_busy_cycles", busy_cycles, FRAME_NP);
    check("post_rst_loads",       load_cnt,    1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
